imem_loader: RTL
================

Name: imem_loader

Overview:
- Front-panel instruction-memory writer: the input-side counterpart of the HEX display path.
- The operator keys hex nibbles on switches and confirms each with a filtered key pulse.
- The block assembles them MSB-first into DATA_W-bit instruction words and writes them to sequential instruction-memory addresses.
- While loading, it holds the processor stopped, and exposes the partial word and address for the 7-segment decoders.

Parameters:
- DATA_W, 16, instruction word width; must be a multiple of 4.
- ADDR_W, 8, instruction memory address width.
- DEPTH, 256, number of writable words; must satisfy 1 <= DEPTH <= 2**ADDR_W.

Ports:
- Clock  input  1  system clock (CLOCK_50 domain).
- Reset  input  1  synchronous, active-high reset.
- LoadEn  input  1  level; load mode request (from a switch).
- Nibble  input  4  hex digit to enter (from switches).
- Enter  input  1  single-cycle pulse from KeyFilter; accepts Nibble.
- Back  input  1  single-cycle pulse; deletes the last entered nibble.
- WrEn  output  1  instruction memory write strobe, one cycle per word.
- WrAddr  output  ADDR_W  write address.
- WrData  output  DATA_W  write data.
- ProcHold  output  1  high whenever not IDLE; processor must not advance.
- Entry  output  DATA_W  partial word being assembled (display).
- DigitCnt  output  log2(DATA_W/4)  nibbles entered in the current word.
- Full  output  1  DEPTH words written this session.

Behaviour:
- Reset: all outputs 0, state IDLE, internal address 0. Reset mid-operation discards the partial word with no write.
- States are IDLE, COLLECT, WRITE, FULL.
- IDLE:
  - ProcHold=0; Enter and Back ignored.
  - LoadEn=1 moves to COLLECT next cycle, with WrAddr=0, Entry=0, DigitCnt=0, Full=0.
- COLLECT:
  - ProcHold=1.
  - Enter: Entry <= {Entry[DATA_W-5:0], Nibble}; DigitCnt+1.
  - On the Enter that completes DATA_W/4 nibbles, go to WRITE next cycle with WrData = the completed word.
  - Back with DigitCnt>0: Entry <= Entry >> 4; DigitCnt-1.
  - Back with DigitCnt=0: no effect.
  - Enter and Back in the same cycle: Enter wins, Back dropped.
- WRITE (exactly 1 cycle):
  - WrEn=1, WrAddr=current address, WrData=assembled word; Enter and Back ignored.
  - Next cycle: WrEn=0, Entry=0, DigitCnt=0.
  - If address = DEPTH-1: Full=1 and go to FULL, address held.
  - Otherwise: address+1 and back to COLLECT.
- Latency: the completing Enter sampled at edge n gives WrEn high during cycle n+1; the incremented WrAddr appears in cycle n+2.
- FULL: ProcHold=1; Enter and Back ignored; WrEn=0.
- LoadEn deassertion:
  - In COLLECT or FULL: go to IDLE next cycle; the partial word is discarded without a write; WrAddr, Entry and Full keep their last values for display.
  - In WRITE: the write completes, then go to IDLE.
- Reassertion of LoadEn from IDLE always restarts at address 0.
- WrData and WrAddr hold their values when WrEn=0. Memory samples only on WrEn.
- No address wrap: a write never occurs at an address >= DEPTH.

Test Plan:
- Enter 1,2,3,4 with LoadEn=1 -> a single WrEn pulse, WrAddr=0x00, WrData=0x1234, one cycle after the 4th Enter. Then Entry=0, DigitCnt=0, WrAddr=0x01.
- Enter A,B, Back, C,D,E -> WrData=0xACDE. A Back at DigitCnt=0 leaves Entry=0 and no write.
- Enter and Back in the same cycle with Nibble=7 after entering 5 -> Entry=0x0057, DigitCnt=2.
- DEPTH=4: write 4 words 0x0001..0x0004 -> addresses 0..3 written, Full=1, ProcHold=1. A further 4 Enters produce no WrEn.
- Enter 9,8, then drop LoadEn -> no WrEn, IDLE, ProcHold=0. Raise LoadEn -> WrAddr=0, Entry=0.
- Reset asserted in WRITE and in COLLECT (DigitCnt=3) -> all outputs 0 next cycle, IDLE, no further WrEn.

Source files
------------

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - operator-input and instruction-memory write bundle for imem_loader
// master: the loader (drives memory write and display); slave: the panel/memory side.
interface imem_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  localparam int CNT_W = (DATA_W / 4 > 1) ? $clog2(DATA_W / 4) : 1;

  logic              load_en;
  logic [3:0]        nibble;
  logic              enter;
  logic              back;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              proc_hold;
  logic [DATA_W-1:0] entry;
  logic [CNT_W-1:0]  digit_cnt;
  logic              full;

  modport master (
    input  load_en, nibble, enter, back,
    output wr_en, wr_addr, wr_data, proc_hold, entry, digit_cnt, full
  );

  modport slave (
    output load_en, nibble, enter, back,
    input  wr_en, wr_addr, wr_data, proc_hold, entry, digit_cnt, full
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - front-panel hex-nibble instruction-memory writer
// Assembles keyed nibbles MSB-first into words and writes them to sequential addresses.
module imem_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  imem_loader_if.master bus
);
  localparam int CNT_W = (DATA_W / 4 > 1) ? $clog2(DATA_W / 4) : 1;
  localparam logic [CNT_W-1:0]  LAST_DIGIT = CNT_W'(DATA_W / 4 - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FULL    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] entry_q, entry_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] shifted;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      entry_q   <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      entry_q   <= entry_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
    end
  end

  // Shift expressed without a part-select so DATA_W=4 stays legal.
  assign shifted = (entry_q << 4) | DATA_W'(bus.nibble);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    entry_d   = entry_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    case (state_q)
      IDLE: begin
        if (bus.load_en) begin
          state_d = COLLECT;
          addr_d  = '0;
          entry_d = '0;
          cnt_d   = '0;
          full_d  = 1'b0;
        end
      end
      COLLECT: begin
        if (!bus.load_en) begin
          state_d = IDLE;
        end else if (bus.enter) begin
          entry_d = shifted;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_DIGIT) begin
            state_d   = WRITE;
            wr_data_d = shifted;
          end
        end else if (bus.back && cnt_q != '0) begin
          entry_d = entry_q >> 4;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      WRITE: begin
        // The write always completes; a dropped LoadEn only redirects to IDLE.
        entry_d = '0;
        cnt_d   = '0;
        if (addr_q == LAST_ADDR) begin
          full_d  = 1'b1;
          state_d = bus.load_en ? FULL : IDLE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = bus.load_en ? COLLECT : IDLE;
        end
      end
      FULL: begin
        if (!bus.load_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.wr_en     = (state_q == WRITE);
  assign bus.wr_addr   = addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.proc_hold = (state_q != IDLE);
  assign bus.entry     = entry_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.full      = full_q;
endmodule
